// File: rtl/fix_msg_buffer.sv
// FIX message store: captures one encoder byte-stream into RAM,
// flags completion, and replays the bytes as the host drains them.
module fix_msg_buffer #(
    parameter int         DEPTH   = 256,
    parameter logic [7:0] CMD_ARM = 8'h11,
    parameter logic [7:0] CMD_CLR = 8'hDD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] session_initiate,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       read_request,
    output logic [7:0] data_out_2,
    output logic [7:0] final_index,
    output logic       fix_message_sent,
    output logic       overflow
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] mem [DEPTH];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    logic       cmd_arm;
    logic       cmd_clr;
    logic       cmd_any;
    logic       wr_en;
    logic       wr_end;
    logic       rd_adv;

    assign cmd_arm  = (session_initiate == CMD_ARM);
    assign cmd_clr  = (session_initiate == CMD_CLR);
    assign cmd_any  = cmd_arm | cmd_clr;
    assign in_ready = (state == FILL);

    // A command in the same cycle wins over any write or read advance.
    assign wr_en  = in_valid & in_ready & ~cmd_any;
    // The message ends on in_last, or is cut off when the RAM is full.
    assign wr_end = wr_en & (in_last | (wr_ptr == LAST_IDX));
    // Read pointer saturates on the last stored byte.
    assign rd_adv = (state == READY) & read_request & ~cmd_any
                  & (rd_ptr < final_index);

    // Next-state decode: commands first, then end of capture.
    always_comb begin
        state_next = state;
        if (cmd_clr) begin
            state_next = IDLE;
        end else if (cmd_arm) begin
            state_next = FILL;
        end else if (wr_end) begin
            state_next = READY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointers, completion flags and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            final_index      <= '0;
            fix_message_sent <= 1'b0;
            overflow         <= 1'b0;
            data_out_2       <= '0;
        end else begin
            data_out_2 <= mem[rd_ptr[AW-1:0]];
            if (cmd_any) begin
                wr_ptr           <= '0;
                rd_ptr           <= '0;
                final_index      <= '0;
                fix_message_sent <= 1'b0;
                overflow         <= 1'b0;
            end else begin
                if (wr_en) begin
                    // Hold at the top so the pointer never leaves the RAM.
                    if (wr_ptr != LAST_IDX) begin
                        wr_ptr <= wr_ptr + 8'd1;
                    end
                    if (wr_end) begin
                        final_index      <= in_last ? wr_ptr : LAST_IDX;
                        fix_message_sent <= 1'b1;
                        overflow         <= overflow | ~in_last;
                    end
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + 8'd1;
                end
            end
        end
    end

    // Message RAM write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_fix_msg_buffer.sv
// Scoreboard bench for fix_msg_buffer (DEPTH=8): stimulus queues expected
// bytes and completions; a negedge monitor pops and compares them.
module tb_fix_msg_buffer;

    localparam logic [7:0] ARM = 8'h11;
    localparam logic [7:0] CLR = 8'hDD;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] session_initiate;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       read_request;
    logic [7:0] data_out_2;
    logic [7:0] final_index;
    logic       fix_message_sent;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_data [$];
    logic [8:0] q_msg  [$];
    logic       fms_prev = 1'b0;

    fix_msg_buffer #(
        .DEPTH  (8),
        .CMD_ARM(ARM),
        .CMD_CLR(CLR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .session_initiate(session_initiate),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .read_request    (read_request),
        .data_out_2      (data_out_2),
        .final_index     (final_index),
        .fix_message_sent(fix_message_sent),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] c);
        session_initiate = c;
        tick();
        session_initiate = 8'h00;
    endtask

    task automatic pulse_read(input logic [7:0] exp);
        q_data.push_back(exp);
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        tick();
    endtask

    // Monitor: byte consumption and message completion events.
    always @(negedge clk) begin
        if (!reset) begin
            if (read_request && fix_message_sent) begin
                if (q_data.size() == 0) begin
                    check("rd_unexpected", 32'(data_out_2), 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", 32'(data_out_2), 32'(q_data.pop_front()));
                end
            end
            if (fix_message_sent && !fms_prev) begin
                if (q_msg.size() == 0) begin
                    check("msg_unexpected", {final_index, overflow}, 32'hFFFF_FFFF);
                end else begin
                    check("msg_final_ovf", 32'({final_index, overflow}),
                          32'(q_msg.pop_front()));
                    check("msg_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
        fms_prev <= fix_message_sent;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t2 [5];
        t2[0] = 8'h38; t2[1] = 8'h3D; t2[2] = 8'h46;
        t2[3] = 8'h49; t2[4] = 8'h58;

        reset            = 1'b1;
        session_initiate = 8'h00;
        in_valid         = 1'b0;
        in_data          = 8'h00;
        in_last          = 1'b0;
        read_request     = 1'b1;

        // T1 reset, read_request held high
        tick();
        tick();
        @(negedge clk);
        check("rst_data",  32'(data_out_2),       32'd0);
        check("rst_final", 32'(final_index),      32'd0);
        check("rst_sent",  32'(fix_message_sent), 32'd0);
        check("rst_ovf",   32'(overflow),         32'd0);
        check("rst_ready", 32'(in_ready),         32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        read_request = 1'b0;
        @(negedge clk);
        check("idle_final", 32'(final_index),      32'd0);
        check("idle_sent",  32'(fix_message_sent), 32'd0);
        check("idle_ready", 32'(in_ready),         32'd0);
        tick();

        // T2 capture of a 5-byte message
        cmd(ARM);
        q_msg.push_back({8'd4, 1'b0});
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = t2[i];
            in_last  = (i == 4);
            @(negedge clk);
            check("t2_in_ready", 32'(in_ready), 32'd1);
            check("t2_not_sent", 32'(fix_message_sent), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("t2_sent",  32'(fix_message_sent), 32'd1);
        check("t2_final", 32'(final_index),      32'd4);
        tick();

        // T3 drain with saturation
        for (int i = 0; i < 5; i++) pulse_read(t2[i]);
        pulse_read(8'h58);

        // T4 overflow: 10 bytes into 8 entries, no in_last
        cmd(ARM);
        q_msg.push_back({8'd7, 1'b1});
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            @(negedge clk);
            check("t4_in_ready", 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_ovf",   32'(overflow),    32'd1);
        check("t4_final", 32'(final_index), 32'd7);
        tick();
        for (int i = 0; i < 8; i++) pulse_read(8'(i + 1));
        pulse_read(8'h08);

        // T5 clear wins over a concurrent write at wr_ptr 0
        cmd(ARM);
        session_initiate = CLR;
        in_valid         = 1'b1;
        in_data          = 8'hEE;
        tick();
        session_initiate = 8'h00;
        in_valid         = 1'b0;
        tick();
        @(negedge clk);
        check("t5_sent",  32'(fix_message_sent), 32'd0);
        check("t5_final", 32'(final_index),      32'd0);
        check("t5_ovf",   32'(overflow),         32'd0);
        check("t5_ready", 32'(in_ready),         32'd0);
        check("t5_mem0",  32'(data_out_2),       32'h01);
        tick();

        // T6 re-arm from READY with a 1-byte message
        cmd(ARM);
        q_msg.push_back({8'd1, 1'b0});
        in_valid = 1'b1;
        in_data  = 8'h10;
        tick();
        in_data  = 8'h20;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        cmd(ARM);
        q_msg.push_back({8'd0, 1'b0});
        in_valid = 1'b1;
        in_data  = 8'hAB;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        @(negedge clk);
        check("t6_data",  32'(data_out_2),  32'hAB);
        check("t6_final", 32'(final_index), 32'd0);
        check("t6_ovf",   32'(overflow),    32'd0);
        tick();
        pulse_read(8'hAB);
        pulse_read(8'hAB);

        // every queued expectation must have been consumed
        tick();
        check("q_data_empty", 32'(q_data.size()), 32'd0);
        check("q_msg_empty",  32'(q_msg.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
